// File: rtl/gmii_rx_frame_writer.sv
// gmii_rx_frame_writer: strips GMII preamble/SFD, writes frame bytes plus a length/status header into a 16K-word ring, publishes a committed write pointer.
module gmii_rx_frame_writer #(
  parameter int MAX_FRAME_BYTES = 1536,
  parameter int MIN_FRAME_BYTES = 14
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RxDv,
  input  logic        RxEr,
  input  logic [7:0]  RxD,
  input  logic [13:0] RdPtr,
  output logic [15:0] RamData,
  output logic [1:0]  RamByteEn,
  output logic [13:0] RamAddress,
  output logic        RamWr,
  output logic [13:0] WrPtr,
  output logic [15:0] FrameCount,
  output logic [15:0] DropCount
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, HEADER} state_t;
  localparam logic [13:0] RESERVE = 14'(1 + (MAX_FRAME_BYTES + 1) / 2);
  localparam logic [11:0] MAX_B = 12'(MAX_FRAME_BYTES);
  localparam logic [11:0] MIN_B = 12'(MIN_FRAME_BYTES);
  state_t state_q, state_d;
  logic        rx_dv_q, rx_er_q;
  logic [7:0]  rx_d_q;
  logic [13:0] start_q, start_d, wr_ptr_q, wr_ptr_d, ram_addr_q, ram_addr_d, free;
  logic [11:0] count_q, count_d;
  logic        err_q, err_d, ram_wr_q, ram_wr_d, take_sfd, space_ok;
  logic [15:0] frame_count_q, frame_count_d, drop_count_q, drop_count_d, ram_data_q, ram_data_d;
  logic [1:0]  ram_be_q, ram_be_d;
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    count_d = count_q;
    err_d = err_q;
    wr_ptr_d = wr_ptr_q;
    frame_count_d = frame_count_q;
    drop_count_d = drop_count_q;
    ram_wr_d = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_be_d = ram_be_q;
    ram_data_d = ram_data_q;
    free = RdPtr - wr_ptr_q - 14'd1;
    space_ok = free >= RESERVE;
    take_sfd = rx_dv_q && rx_d_q == 8'hD5 && (state_q == IDLE || state_q == PREAMBLE);
    case (state_q)
      IDLE: state_d = rx_dv_q ? PREAMBLE : IDLE;
      PREAMBLE: state_d = !rx_dv_q ? IDLE : (rx_d_q == 8'h55 ? PREAMBLE : DROP);
      DATA: begin
        if (rx_dv_q) begin
          err_d = err_q | rx_er_q | (count_q >= MAX_B);
          if (count_q < MAX_B) begin
            ram_wr_d = 1'b1;
            ram_addr_d = start_q + 14'd1 + 14'(count_q >> 1);
            ram_be_d = count_q[0] ? 2'b10 : 2'b01;
            ram_data_d = count_q[0] ? {rx_d_q, 8'h00} : {8'h00, rx_d_q};
            count_d = count_q + 12'd1;
          end
        end else if (count_q < MIN_B) begin
          drop_count_d = drop_count_q + 16'd1;
          state_d = IDLE;
        end else begin
          // header goes out while in HEADER; the pointer commits one cycle later
          ram_wr_d = 1'b1;
          ram_addr_d = start_q;
          ram_be_d = 2'b11;
          ram_data_d = {err_q, 3'b000, count_q};
          state_d = HEADER;
        end
      end
      HEADER: begin
        wr_ptr_d = start_q + 14'd1 + 14'((count_q + 12'd1) >> 1);
        frame_count_d = frame_count_q + 16'd1;
        state_d = IDLE;
      end
      DROP: state_d = rx_dv_q ? DROP : IDLE;
      default: state_d = IDLE;
    endcase
    if (take_sfd) begin
      state_d = space_ok ? DATA : DROP;
      start_d = wr_ptr_q;
      count_d = 12'd0;
      err_d = 1'b0;
      drop_count_d = space_ok ? drop_count_q : drop_count_q + 16'd1;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      rx_dv_q <= 1'b0;
      rx_er_q <= 1'b0;
      rx_d_q <= 8'h00;
      start_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
      wr_ptr_q <= '0;
      frame_count_q <= '0;
      drop_count_q <= '0;
      ram_wr_q <= 1'b0;
      ram_addr_q <= '0;
      ram_be_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q <= state_d;
      rx_dv_q <= RxDv;
      rx_er_q <= RxEr;
      rx_d_q <= RxD;
      start_q <= start_d;
      count_q <= count_d;
      err_q <= err_d;
      wr_ptr_q <= wr_ptr_d;
      frame_count_q <= frame_count_d;
      drop_count_q <= drop_count_d;
      ram_wr_q <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_be_q <= ram_be_d;
      ram_data_q <= ram_data_d;
    end
  end
  assign RamData = ram_data_q;
  assign RamByteEn = ram_be_q;
  assign RamAddress = ram_addr_q;
  assign RamWr = ram_wr_q;
  assign WrPtr = wr_ptr_q;
  assign FrameCount = frame_count_q;
  assign DropCount = drop_count_q;
endmodule

// File: doc/gmii_rx_frame_writer.md
Name: gmii_rx_frame_writer

Overview:
- Receive-side stage directly upstream of the 16-bit x 16K byte-enabled dual-port frame RAM; drives that RAM's write port (port A side).
- Strips preamble/SFD from 8-bit GMII receive data and writes each byte with the RAM byte enables.
- Prepends a one-word length/status header and publishes a committed write pointer to the host-side reader.
- The RAM is used as a ring of 16384 words.

Parameters:
- MAX_FRAME_BYTES, 1536, bytes stored per frame; later bytes are discarded and the frame is flagged as an error.
- MIN_FRAME_BYTES, 14, frames shorter than this are dropped and never committed.

Ports:
- Clock  in  1  single clock, GMII receive domain.
- Reset  in  1  synchronous, active-high.
- RxDv  in  1  GMII receive data valid.
- RxEr  in  1  GMII receive error.
- RxD  in  8  GMII receive data.
- RdPtr  in  14  reader's next word address; RdPtr == WrPtr means the ring is empty.
- RamData  out  16  RAM write data.
- RamByteEn  out  2  RAM byte enables.
- RamAddress  out  14  RAM word address.
- RamWr  out  1  RAM write strobe.
- WrPtr  out  14  committed write pointer: first word after the last committed frame.
- FrameCount  out  16  committed frames, wraps.
- DropCount  out  16  dropped frames (no space or runt), wraps.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - A partial frame in progress is discarded and not committed; WrPtr returns to 0.
- Inputs and latency:
  - RxDv/RxEr/RxD are registered once on entry.
  - All RAM outputs are registered.
  - A data byte's RAM write appears 2 cycles after it is on RxD.
- States: IDLE, PREAMBLE, DATA, DROP, HEADER.
- IDLE:
  - RxDv=1 goes to PREAMBLE.
  - If the first byte is 0xD5, treat it as the SFD directly.
- PREAMBLE:
  - 0x55 bytes are ignored.
  - 0xD5 performs the space check (below) and goes to DATA or DROP.
  - RxDv=0 returns to IDLE with no count.
  - Any other byte goes to DROP, no count.
- Space check, evaluated on the SFD cycle:
  - free = (RdPtr - WrPtr - 1) mod 16384.
  - Need free >= 1 + ceil(MAX_FRAME_BYTES/2), which is 769 at the default.
  - Pass: start = WrPtr, byte count = 0, err = 0, go to DATA.
  - Fail: DropCount+1, go to DROP.
- DATA, per byte n (0-based, n < MAX_FRAME_BYTES):
  - Word address = (start + 1 + n/2) mod 16384.
  - n even: RamByteEn=01, RamData={8'h00,byte}.
  - n odd: RamByteEn=10, RamData={byte,8'h00}.
  - RamWr=1 for exactly one cycle per byte.
  - RxEr=1 on any byte sets err.
  - Bytes at n >= MAX_FRAME_BYTES: no write, err=1, count saturates.
  - RxDv falling ends the frame.
- Frame end:
  - count < MIN_FRAME_BYTES: DropCount+1, go to IDLE, WrPtr unchanged, no header write. Data writes already issued are harmless because the region is not committed.
  - Otherwise go to HEADER.
- HEADER (one cycle):
  - RamWr=1, RamByteEn=11, RamAddress=start.
  - RamData = {err, 3'b000, count[11:0]}.
  - Next cycle: WrPtr = (start + 1 + ceil(count/2)) mod 16384, FrameCount+1, go to IDLE.
  - WrPtr never changes except at this commit (or reset).
- DROP: no RAM writes; wait for RxDv=0, then IDLE.
- Back-to-back frames:
  - RxDv reasserted during HEADER is not sampled until IDLE.
  - Loses at most one preamble byte; the frame is still received.
- Wrap-around: every address computation is mod 16384; data and headers wrap from 16383 to 0 transparently.
- RdPtr:
  - Sampled only at the SFD.
  - Later changes during a frame do not abort it; the reservation guarantees no overrun.
- RamWr is 0 in IDLE, PREAMBLE and DROP.

Test Plan:
1. Reset, RdPtr=0. Send 7x0x55, 0xD5, bytes 0x00..0x3F (64). Expect:
   - 64 writes at addr 1..32, ByteEn alternating 01/10; addr 1 gets 0x00 then 0x01.
   - Header write addr 0, data 0x0040.
   - WrPtr=33, FrameCount=1.
2. Next, a 61-byte frame. Expect:
   - Final write addr 64, ByteEn=01.
   - Header at addr 33 = 0x003D.
   - WrPtr=33+1+31=65.
3. 64-byte frame with RxEr on byte 20 → header 0x8040; committed normally (FrameCount+1).
4. Drive WrPtr to 16370 via prior frames, reader keeping up. Send a 64-byte frame. Expect:
   - Data addresses 16371..16383 then 0..18.
   - Header at 16370.
   - WrPtr=19.
5. WrPtr=33, RdPtr=134 (free=100 < 769), send 64-byte frame → no RamWr, DropCount+1, WrPtr=33.
6. Runt and reset cases:
   - 10-byte frame → DropCount+1, no header write, WrPtr unchanged.
   - Separately, assert Reset after 30 data bytes → all outputs 0, WrPtr=0, FrameCount unchanged at 0.
